// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: ROM address/data, decoder handshake, branch redirect and status.
// Signal directions are named from the fetch stage's point of view.
interface inst_fetch_if;
    logic        i_start;
    logic [7:0]  o_inst_address;
    logic [9:0]  i_inst_in;
    logic [9:0]  o_inst_out;
    logic        o_inst_valid;
    logic        i_inst_ready;
    logic        i_branch_taken;
    logic [7:0]  i_branch_target;
    logic        o_halted;
    logic [15:0] o_fetch_count;

    modport slave (
        input  i_start, i_inst_in, i_inst_ready, i_branch_taken, i_branch_target,
        output o_inst_address, o_inst_out, o_inst_valid, o_halted, o_fetch_count
    );

    modport master (
        output i_start, i_inst_in, i_inst_ready, i_branch_taken, i_branch_target,
        input  o_inst_address, o_inst_out, o_inst_valid, o_halted, o_fetch_count
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, instruction register with valid/ready handoff,
// branch redirect, halt detection and saturating issue counter.
//
// state   | meaning
// S_IDLE  | after reset, waiting for Start
// S_RUN   | fetching one word per cycle when the decoder keeps up
// S_HALTED| halt word fetched, fetch stopped until Start
module inst_fetch #(
    parameter logic [7:0] RESET_PC = 8'd0,
    parameter logic [3:0] HALT_OP  = 4'b0001
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    inst_fetch_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [7:0]  r_pc;
    logic [9:0]  r_inst_out;
    logic        r_inst_valid;
    logic        r_halted;
    logic [15:0] r_fetch_count;

    logic [7:0]  w_pc_nxt;
    logic [9:0]  w_inst_out_nxt;
    logic        w_inst_valid_nxt;
    logic        w_halted_nxt;
    logic [15:0] w_fetch_count_nxt;

    logic        w_load;
    logic        w_is_halt;
    logic [15:0] w_count_inc;

    assign w_load      = !r_inst_valid || bus.i_inst_ready;
    assign w_is_halt   = (bus.i_inst_in[9:6] == HALT_OP);
    assign w_count_inc = (r_fetch_count == 16'hFFFF) ? r_fetch_count : r_fetch_count + 16'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.i_start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // A redirect wins over a halt word sitting on the ROM bus.
                if (!bus.i_branch_taken && w_load && w_is_halt) begin
                    w_state_nxt = S_HALTED;
                end
            end
            S_HALTED: begin
                if (bus.i_start) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_pc_nxt          = r_pc;
        w_inst_out_nxt    = r_inst_out;
        w_inst_valid_nxt  = r_inst_valid;
        w_halted_nxt      = r_halted;
        w_fetch_count_nxt = r_fetch_count;
        case (r_state)
            S_IDLE: begin
                if (bus.i_start) begin
                    w_pc_nxt          = RESET_PC;
                    w_inst_valid_nxt  = 1'b0;
                    w_halted_nxt      = 1'b0;
                    w_fetch_count_nxt = 16'd0;
                end
            end
            S_RUN: begin
                if (bus.i_branch_taken) begin
                    w_pc_nxt         = bus.i_branch_target;
                    w_inst_valid_nxt = 1'b0;
                end else if (w_load) begin
                    w_inst_out_nxt    = bus.i_inst_in;
                    w_inst_valid_nxt  = 1'b1;
                    w_fetch_count_nxt = w_count_inc;
                    if (w_is_halt) begin
                        w_halted_nxt = 1'b1;
                    end else begin
                        w_pc_nxt = r_pc + 8'd1;
                    end
                end
            end
            S_HALTED: begin
                if (bus.i_start) begin
                    w_pc_nxt          = RESET_PC;
                    w_inst_valid_nxt  = 1'b0;
                    w_halted_nxt      = 1'b0;
                    w_fetch_count_nxt = 16'd0;
                end else if (bus.i_inst_ready) begin
                    w_inst_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_inst_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc          <= RESET_PC;
            r_inst_out    <= 10'b0;
            r_inst_valid  <= 1'b0;
            r_halted      <= 1'b0;
            r_fetch_count <= 16'd0;
        end else begin
            r_pc          <= w_pc_nxt;
            r_inst_out    <= w_inst_out_nxt;
            r_inst_valid  <= w_inst_valid_nxt;
            r_halted      <= w_halted_nxt;
            r_fetch_count <= w_fetch_count_nxt;
        end
    end

    assign bus.o_inst_address = r_pc;
    assign bus.o_inst_out     = r_inst_out;
    assign bus.o_inst_valid   = r_inst_valid;
    assign bus.o_halted       = r_halted;
    assign bus.o_fetch_count  = r_fetch_count;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: linear run, stall, branch, branch-over-halt,
// PC wrap and asynchronous reset mid-run against a combinational ROM.
module tb_inst_fetch;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [9:0] rom [256];

    inst_fetch_if bus ();

    inst_fetch #(
        .RESET_PC (8'd0),
        .HALT_OP  (4'b0001)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    assign bus.i_inst_in = rom[bus.o_inst_address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_io(input string tag, input logic [9:0] out, input logic [7:0] addr,
                            input logic [15:0] cnt);
        check({tag, " out"},   16'(bus.o_inst_out),     16'(out));
        check({tag, " addr"},  16'(bus.o_inst_address), 16'(addr));
        check({tag, " count"}, bus.o_fetch_count,       cnt);
        check({tag, " valid"}, 16'(bus.o_inst_valid),   16'h1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        // Non-halt words tag themselves with 2'b11 above the address; halts at 7 and 40.
        for (int i = 0; i < 256; i++) rom[i] = {2'b11, 8'(i)};
        rom[7]  = 10'b0001_000000;
        rom[40] = 10'b0001_000000;

        rst_n               = 1'b0;
        bus.i_start         = 1'b0;
        bus.i_inst_ready    = 1'b1;
        bus.i_branch_taken  = 1'b0;
        bus.i_branch_target = 8'd0;

        #12;
        check("rst addr",   16'(bus.o_inst_address), 16'h0);
        check("rst out",    16'(bus.o_inst_out),     16'h0);
        check("rst valid",  16'(bus.o_inst_valid),   16'h0);
        check("rst halted", 16'(bus.o_halted),       16'h0);
        check("rst count",  bus.o_fetch_count,       16'h0);
        rst_n = 1'b1;

        // Idle ignores a branch request
        bus.i_branch_taken  = 1'b1;
        bus.i_branch_target = 8'd50;
        tick();
        bus.i_branch_taken  = 1'b0;
        check("idle branch addr", 16'(bus.o_inst_address), 16'h0);

        // Linear run with a three-cycle stall on ROM[2]
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        check("start addr",  16'(bus.o_inst_address), 16'h0);
        check("start valid", 16'(bus.o_inst_valid),   16'h0);
        tick(); check_io("lin0", 10'h300, 8'd1, 16'd1);
        tick(); check_io("lin1", 10'h301, 8'd2, 16'd2);
        tick(); check_io("lin2", 10'h302, 8'd3, 16'd3);
        bus.i_inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); check_io("stall", 10'h302, 8'd3, 16'd3);
        end
        bus.i_inst_ready = 1'b1;
        tick(); check_io("lin3", 10'h303, 8'd4, 16'd4);
        bus.i_start = 1'b1;
        tick(); check_io("lin4 start ignored", 10'h304, 8'd5, 16'd5);
        bus.i_start = 1'b0;
        tick(); check_io("lin5", 10'h305, 8'd6, 16'd6);
        tick(); check_io("lin6", 10'h306, 8'd7, 16'd7);
        check("lin6 halted", 16'(bus.o_halted), 16'h0);
        tick(); check_io("lin7 halt", 10'h040, 8'd7, 16'd8);
        check("lin7 halted", 16'(bus.o_halted), 16'h1);
        tick();
        check("halt valid drop", 16'(bus.o_inst_valid),   16'h0);
        check("halt out hold",   16'(bus.o_inst_out),     16'h040);
        check("halt addr hold",  16'(bus.o_inst_address), 16'h7);
        bus.i_branch_taken  = 1'b1;
        bus.i_branch_target = 8'd24;
        tick();
        bus.i_branch_taken  = 1'b0;
        check("halt branch ignored", 16'(bus.o_inst_address), 16'h7);
        check("halt stays",          16'(bus.o_halted),       16'h1);

        // Restart from HALTED, then branch to 24 while PC=5
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        check("restart addr",   16'(bus.o_inst_address), 16'h0);
        check("restart halted", 16'(bus.o_halted),       16'h0);
        check("restart count",  bus.o_fetch_count,       16'h0);
        check("restart valid",  16'(bus.o_inst_valid),   16'h0);
        for (int i = 0; i < 5; i++) tick();
        check_io("pre branch", 10'h304, 8'd5, 16'd5);
        bus.i_branch_taken  = 1'b1;
        bus.i_branch_target = 8'd24;
        tick();
        bus.i_branch_taken  = 1'b0;
        check("br bubble valid", 16'(bus.o_inst_valid),   16'h0);
        check("br bubble addr",  16'(bus.o_inst_address), 16'h18);
        check("br bubble count", bus.o_fetch_count,       16'd5);
        tick(); check_io("br target", 10'h318, 8'd25, 16'd6);

        // Branch coinciding with a halt word on the ROM bus
        bus.i_branch_taken  = 1'b1;
        bus.i_branch_target = 8'd39;
        tick();
        bus.i_branch_taken  = 1'b0;
        tick(); check_io("bh pre", 10'h327, 8'd40, 16'd7);
        bus.i_branch_taken  = 1'b1;
        bus.i_branch_target = 8'd100;
        tick();
        bus.i_branch_taken  = 1'b0;
        check("bh halted", 16'(bus.o_halted),       16'h0);
        check("bh valid",  16'(bus.o_inst_valid),   16'h0);
        check("bh addr",   16'(bus.o_inst_address), 16'h64);
        tick(); check_io("bh target", 10'h364, 8'd101, 16'd8);
        check("bh halted after", 16'(bus.o_halted), 16'h0);

        // PC wrap 255 -> 0
        bus.i_branch_taken  = 1'b1;
        bus.i_branch_target = 8'd255;
        tick();
        bus.i_branch_taken  = 1'b0;
        tick(); check_io("wrap 255", 10'h3FF, 8'd0, 16'd9);
        tick(); check_io("wrap 0",   10'h300, 8'd1, 16'd10);

        // Run to halt, hold valid, then asynchronous reset between edges
        for (int i = 0; i < 7; i++) tick();
        check_io("halt2", 10'h040, 8'd7, 16'd17);
        bus.i_inst_ready = 1'b0;
        check("halt2 halted", 16'(bus.o_halted), 16'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst addr",   16'(bus.o_inst_address), 16'h0);
        check("arst out",    16'(bus.o_inst_out),     16'h0);
        check("arst valid",  16'(bus.o_inst_valid),   16'h0);
        check("arst halted", 16'(bus.o_halted),       16'h0);
        check("arst count",  bus.o_fetch_count,       16'h0);
        #1;
        rst_n            = 1'b1;
        bus.i_inst_ready = 1'b1;
        bus.i_start      = 1'b1;
        tick();
        bus.i_start = 1'b0;
        tick(); check_io("post rst", 10'h300, 8'd1, 16'd1);
        tick(); check_io("post rst2", 10'h301, 8'd2, 16'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
